// File: rtl/expand.sv
// -----------------------------------------------------------------------------
// expand: broadcasts a COLS-element signed vector into a ROWS x COLS matrix.
// Each WRITE cycle writes one row, and each row is a copy of the vector.
//
// Control uses enable / busy / done.
//   - enable is level-held for the whole run. Dropping it aborts the run
//     without a done pulse.
//   - busy is high in LOAD and WRITE.
//   - done is a one-cycle pulse in DONE.
//
// Timing from the rising edge of enable:
//   - E0: IDLE -> LOAD
//   - E1: capture vector_in
//   - E2..E(ROWS+1): write rows 0..ROWS-1
//   - done is high in the cycle after the last row write.
//
// Optional build macro EXPAND_RESIDUAL_EN:
//   - Each written element becomes sat(vec_reg[c] + residual_in[r][c]).
//   - The sum is saturated to the signed DW-bit range.
//   - Without the macro, residual_in is ignored and the output is a pure copy.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears matrix_out too)
//   enable       start / hold
//   vector_in    [COLS] signed source vector, sampled once on LOAD exit
//   residual_in  [ROWS][COLS] signed residual (EXPAND_RESIDUAL_EN only)
//   matrix_out   [ROWS][COLS] signed registered result
//   busy         high in LOAD and WRITE
//   done         high for the single DONE cycle
// -----------------------------------------------------------------------------
module expand #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic signed [DW-1:0] vector_in   [COLS],
  input  logic signed [DW-1:0] residual_in [ROWS][COLS],
  output logic signed [DW-1:0] matrix_out  [ROWS][COLS],
  output logic                 busy,
  output logic                 done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [RW-1:0]        row_cnt;
  logic signed [DW-1:0] vec_reg [COLS];

`ifdef EXPAND_RESIDUAL_EN
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Adds at DW+1 bits. The top two bits of the sum differ exactly when
  // the result does not fit in DW bits. The carry bit gives the direction.
  function automatic logic signed [DW-1:0] sat_add(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic [DW:0] sum;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] != sum[DW-1]) return sum[DW] ? SAT_MIN : SAT_MAX;
    return sum[DW-1:0];
  endfunction
`else
  // The residual input exists only for port compatibility in this build.
  // This reduction gives it a sink.
  logic unused_residual;
  always_comb begin
    unused_residual = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        unused_residual = unused_residual ^ (^residual_in[r][c]);
  end
`endif

  // NOTE: every combinational output gets a default before the case.
  // An unassigned path would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = LOAD;
      LOAD:    next_state = enable ? WRITE : IDLE;
      WRITE:   if (!enable)                next_state = IDLE;
               else if (row_cnt == LAST_ROW) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == WRITE);
  assign done = (state == DONE);

  // NOTE: state is written with non-blocking assignments only. All
  // registers then update together at the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      // NOTE: the matrix is reset. Downstream stages may read it before
      // the first run completes, and a reset mid-run must clear it at once.
      for (int c = 0; c < COLS; c++) vec_reg[c] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) matrix_out[r][c] <= '0;
    end else begin
      state <= next_state;
      case (state)
        LOAD: begin
          for (int c = 0; c < COLS; c++) vec_reg[c] <= vector_in[c];
          row_cnt <= '0;
        end
        WRITE: begin
          if (enable) begin
            for (int c = 0; c < COLS; c++) begin
`ifdef EXPAND_RESIDUAL_EN
              matrix_out[row_cnt][c] <= sat_add(vec_reg[c], residual_in[row_cnt][c]);
`else
              matrix_out[row_cnt][c] <= vec_reg[c];
`endif
            end
            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
          end else begin
            // An aborted run keeps the rows it already wrote.
            row_cnt <= '0;
          end
        end
        default: row_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_expand.sv
// -----------------------------------------------------------------------------
// tb_expand: directed self-checking bench for expand (16x16, DW=8).
//
// It compares DUT outputs against a local model matrix of expected element
// values. The same bench serves both builds, and the residual expectations
// follow EXPAND_RESIDUAL_EN.
// -----------------------------------------------------------------------------
module tb_expand;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int DW   = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic signed [DW-1:0] vector_in   [COLS];
  logic signed [DW-1:0] residual_in [ROWS][COLS];
  logic signed [DW-1:0] matrix_out  [ROWS][COLS];
  logic                 busy;
  logic                 done;

  int exp_mat [ROWS][COLS];
  int n_checks;
  int n_errors;

  expand #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .vector_in   (vector_in),
    .residual_in (residual_in),
    .matrix_out  (matrix_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts the elements that differ from the model, then checks the count.
  task automatic check_matrix(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (int'(matrix_out[r][c]) != exp_mat[r][c]) bad++;
    check(tag, bad, 0);
  endtask

  // Raises enable and checks three things: the edges until done, the busy
  // cycle count, and that done lasts a single cycle. The caller updates the
  // model and then checks the matrix.
  task automatic full_run(input string tag);
    int edges;
    int busy_cycles;
    int both;
    edges = -1;
    busy_cycles = 0;
    both = 0;
    enable = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (busy) busy_cycles++;
      if (busy && done) both++;
      if (done) begin
        edges = n;
        break;
      end
    end
    enable = 1'b0;
    check({tag, "_done_latency"}, edges, ROWS + 2);
    check({tag, "_busy_cycles"}, busy_cycles, ROWS + 1);
    check({tag, "_busy_and_done"}, both, 0);
    tick();
    check({tag, "_done_width"}, int'(done), 0);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    n_checks = 0;
    n_errors = 0;

    // --- Reset values under random inputs ---
    rst_n  = 1'b0;
    enable = 1'($urandom_range(0, 1));
    for (int c = 0; c < COLS; c++) vector_in[c] = DW'($urandom);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) residual_in[r][c] = DW'($urandom);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_mat[r][c] = 0;
    repeat (3) tick();
    check_matrix("reset_matrix");
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    enable = 1'b0;
    rst_n  = 1'b1;
    busy_seen = 0;
    done_seen = 0;
    repeat (10) begin
      tick();
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("idle_busy", busy_seen, 0);
    check("idle_done", done_seen, 0);
    check_matrix("idle_matrix");

    // --- Basic broadcast, vector[c] = c-8, zero residual ---
    for (int c = 0; c < COLS; c++) vector_in[c] = DW'(c - 8);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) residual_in[r][c] = '0;
    full_run("basic");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_mat[r][c] = c - 8;
    check_matrix("basic_matrix");

    // --- Enable held high: a one-cycle IDLE gap, then a restart ---
    // full_run ends one edge after DONE, so the DUT is now in IDLE.
    enable = 1'b1;
    check("restart_gap_busy", int'(busy), 0);
    tick();
    check("restart_load_busy", int'(busy), 1);
    enable = 1'b0;
    tick();
    check("restart_abort_busy", int'(busy), 0);
    check_matrix("restart_abort_matrix");

    // --- Capture isolation: vector changes after capture ---
    for (int c = 0; c < COLS; c++) vector_in[c] = DW'(3 * c - 20);
    enable = 1'b1;
    tick();                                           // E0: LOAD
    tick();                                           // E1: capture
    for (int c = 0; c < COLS; c++) vector_in[c] = 8'h7F;
    done_seen = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done) begin
        done_seen = n;
        break;
      end
    end
    enable = 1'b0;
    check("capture_done_after_rows", done_seen, ROWS - 1);
    tick();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_mat[r][c] = 3 * c - 20;
    check_matrix("capture_matrix");

    // --- Abort after row 5 is written ---
    for (int c = 0; c < COLS; c++) vector_in[c] = DW'(40 - 5 * c);
    enable = 1'b1;
    repeat (8) tick();                                // E0..E7, rows 0..5 written
    enable = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    repeat (4) begin
      tick();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check("abort_done", done_seen, 0);
    check("abort_busy", busy_seen, 0);
    for (int r = 0; r <= 5; r++)
      for (int c = 0; c < COLS; c++) exp_mat[r][c] = 40 - 5 * c;
    check_matrix("abort_matrix");

    full_run("after_abort");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_mat[r][c] = 40 - 5 * c;
    check_matrix("after_abort_matrix");

    // --- Async reset mid-WRITE at row 9 ---
    for (int c = 0; c < COLS; c++) vector_in[c] = DW'(c + 1);
    enable = 1'b1;
    repeat (12) tick();                               // rows 0..9 written
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_mat[r][c] = 0;
    check_matrix("async_reset_matrix");
    check("async_reset_busy", int'(busy), 0);
    done_seen = 0;
    repeat (2) begin
      tick();
      if (done) done_seen++;
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (20) begin
      tick();
      if (done) done_seen++;
    end
    check("async_reset_done", done_seen, 0);

    // --- Residual saturation pattern ---
    for (int c = 0; c < COLS; c++) begin
      case (c % 3)
        0:       vector_in[c] = 8'sd100;
        1:       vector_in[c] = -8'sd100;
        default: vector_in[c] = 8'sd5;
      endcase
      for (int r = 0; r < ROWS; r++) begin
        case (c % 3)
          0:       residual_in[r][c] = 8'sd100;
          1:       residual_in[r][c] = -8'sd100;
          default: residual_in[r][c] = -8'sd3;
        endcase
      end
    end
    full_run("residual");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
`ifdef EXPAND_RESIDUAL_EN
        exp_mat[r][c] = (c % 3 == 0) ? 127 : (c % 3 == 1) ? -128 : 2;
`else
        exp_mat[r][c] = (c % 3 == 0) ? 100 : (c % 3 == 1) ? -100 : 5;
`endif
      end
    check_matrix("residual_matrix");
    check("residual_pos_elem", int'(matrix_out[4][0]), exp_mat[4][0]);
    check("residual_neg_elem", int'(matrix_out[11][1]), exp_mat[11][1]);
    check("residual_mix_elem", int'(matrix_out[15][2]), exp_mat[15][2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/expand.md
Name: expand

Overview:
- Inverse-direction companion to the column-mean reduction stage: takes a 16-element signed vector and broadcasts it back into a 16x16 matrix.
- Writes one row per clock: `matrix_out[r][c] = vector_in[c]` for every row r.
- Used where a pooled/summary vector must be re-applied across all rows of the token matrix, e.g. a broadcast add ahead of the next matrix stage.
- Same level-held `enable` / one-cycle `done` control style as the reduction stage.

Parameters:
- ROWS, 16, number of output rows written (one per cycle).
- COLS, 16, vector length and output row width.
- DW, 8, signed data width of vector, matrix and residual elements.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  start/hold; must stay 1 for the whole operation.
- vector_in  input  [DW-1:0] x COLS, signed  source vector; sampled once at start.
- residual_in  input  [DW-1:0] x ROWS x COLS, signed  used only with EXPAND_RESIDUAL_EN; otherwise present but ignored.
- matrix_out  output  [DW-1:0] x ROWS x COLS, signed  registered result matrix.
- busy  output  1  high in LOAD and WRITE states.
- done  output  1  one-cycle pulse, high in DONE state.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, row_cnt=0, vec_reg all 0, matrix_out all 0, busy=0, done=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE -> LOAD when enable=1, else stay.
- LOAD -> WRITE if enable=1, else IDLE. On the LOAD-exit edge, vector_in is captured into vec_reg; row_cnt=0.
- WRITE:
  - Each edge writes row row_cnt: `matrix_out[row_cnt][c] <= vec_reg[c]` for all c.
  - row_cnt increments; at row_cnt==ROWS-1 it wraps to 0 and the state goes to DONE.
- DONE -> IDLE unconditionally. A new operation requires enable=1 sampled in IDLE. If enable is held high continuously, the block restarts after a 1-cycle IDLE gap.
- Latency: enable rises before edge E0 (IDLE->LOAD).
  - E1 captures the vector.
  - E2..E17 write rows 0..ROWS-1.
  - done=1 for the cycle after E17.
  - Total ROWS+2 edges from enable to done.
- done and busy are decoded from state, not registered separately. busy and done are never both 1.
- matrix_out holds its last value outside WRITE. It is not cleared on a new start; rows are overwritten as written.
- Abort: enable=0 in LOAD or WRITE -> next state IDLE, row_cnt -> 0, no done pulse. Rows already written are kept; unwritten rows keep their old contents.
- vector_in changes after capture do not affect the result.
- Mid-operation rst_n assertion: immediate return to reset values, including matrix_out cleared.
- Arithmetic without the option: pure copy, no width change.

Optional Feature:
- Macro: EXPAND_RESIDUAL_EN.
- Defined:
  - WRITE computes `matrix_out[r][c] <= sat(vec_reg[c] + residual_in[r][c])`.
  - The sum is formed at DW+1 bits signed, then saturated to [-2^(DW-1), 2^(DW-1)-1], i.e. [-128, 127] for DW=8.
  - residual_in row r is sampled on the edge that writes row r; it must be stable during WRITE.
- Undefined: residual_in is ignored, no adder or saturation logic is generated, output is the pure broadcast.
- Timing and control are identical in both builds.

Test Plan:
- Reset values: hold rst_n=0 with random inputs -> matrix_out all 0, busy=0, done=0. Release and keep enable=0 for 10 cycles -> state stays IDLE, outputs unchanged.
- Basic broadcast: `vector_in[c]=c-8`, enable held high -> done pulses exactly 18 edges after enable rise, for exactly 1 cycle. All rows r have `matrix_out[r][c]=c-8`. busy=1 for 17 cycles.
- Capture isolation: change vector_in to all 0x7F one cycle after LOAD -> result still equals the original vector in all 16 rows.
- Abort: enable dropped after row 5 is written -> no done pulse. Rows 0..5 hold the new vector; rows 6..15 hold the previous contents. Next enable gives a full 18-edge run.
- Async reset mid-WRITE: assert rst_n=0 at row 9 -> matrix_out is all 0 immediately, before the next clk edge; no done pulse.
- EXPAND_RESIDUAL_EN build:
  - vec=100, residual=100 -> 127.
  - vec=-100, residual=-100 -> -128.
  - vec=5, residual=-3 -> 2.
  - Non-EXPAND_RESIDUAL_EN build, same stimulus -> output equals vec.
